// File: rtl/axon_pkg.sv
// Shared types and helpers for the multi-channel axon delay line.
// Delay values double as due-time stamps, so both use delay_t.
package axon_pkg;
    localparam int DELAY_W   = 6;
    localparam int MIN_DELAY = 1;
    // One spare bit above the default 4-channel index so out-of-range channels can be presented and rejected.
    localparam int CH_IDX_W  = $clog2(4) + 1;

    typedef logic [DELAY_W-1:0] delay_t;

    function automatic delay_t eff_delay(input delay_t d);
        return (d == '0) ? delay_t'(MIN_DELAY) : d;
    endfunction
endpackage

// File: rtl/axon_due_fifo.sv
// Per-channel FIFO of spike due times; head is combinational, one-cycle write-to-head latency.
// A push while full is accepted only when a pop happens in the same cycle; otherwise it is ignored.
module axon_due_fifo
    import axon_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [DELAY_W-1:0] push_due,
    input  logic               pop,
    output logic [DELAY_W-1:0] head,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);

    delay_t          mem [DEPTH];
    logic   [AW:0]   wr_ptr;
    logic   [AW:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_due;
    end
endmodule

// File: rtl/axon_delay_line.sv
// N_CH independent axon delays, each holding up to DEPTH spikes in flight; spike out eff cycles after sampling.
// No backpressure: a spike arriving at a full channel with no same-cycle release is dropped and flagged sticky.
module axon_delay_line
    import axon_pkg::*;
#(
    parameter  int N_CH          = 4,
    parameter  int DEPTH         = 8,
    parameter  int DEFAULT_DELAY = 1,
    localparam int CW            = $clog2(N_CH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_CH-1:0]    spike_in,
    output logic [N_CH-1:0]    spike_out,
    input  logic               cfg_we,
    input  logic [CW-1:0]      cfg_ch,
    input  logic [DELAY_W-1:0] cfg_delay,
    output logic               cfg_ack,
    output logic               cfg_err,
    output logic [N_CH-1:0]    busy,
    output logic [N_CH-1:0]    overflow,
    input  logic               ovf_clr
);
    delay_t          now;
    delay_t          delay_q [N_CH];
    delay_t          head    [N_CH];
    logic [N_CH-1:0] full;
    logic [N_CH-1:0] empty;
    logic [N_CH-1:0] pop;
    logic [N_CH-1:0] drop;
    logic            cfg_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) now <= '0;
        else       now <= now + delay_t'(1);
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        delay_t due_in;

        // Due stamps are the `now` value at the release edge, so matching against the current count
        // releases exactly eff edges after sampling; in-channel order is monotonic so equality is wrap-safe.
        assign due_in  = now + eff_delay(delay_q[c]);
        assign pop[c]  = !empty[c] && (head[c] == now);
        assign drop[c] = spike_in[c] && full[c] && !pop[c];

        axon_due_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .push     (spike_in[c]),
            .push_due (due_in),
            .pop      (pop[c]),
            .head     (head[c]),
            .full     (full[c]),
            .empty    (empty[c])
        );
    end

    assign busy = ~empty;

    // A delay may only change while its channel is idle, which keeps due times monotonic.
    always_comb begin
        cfg_ok = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (cfg_ch == CW'(c)) cfg_ok = !busy[c] && !spike_in[c];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spike_out <= '0;
            overflow  <= '0;
            cfg_ack   <= 1'b0;
            cfg_err   <= 1'b0;
            for (int c = 0; c < N_CH; c++) delay_q[c] <= delay_t'(DEFAULT_DELAY);
        end else begin
            spike_out <= pop;
            overflow  <= drop | (overflow & ~{N_CH{ovf_clr}});
            cfg_ack   <= cfg_we && cfg_ok;
            cfg_err   <= cfg_we && !cfg_ok;
            for (int c = 0; c < N_CH; c++) begin
                if (cfg_we && cfg_ok && (cfg_ch == CW'(c))) delay_q[c] <= cfg_delay;
            end
        end
    end
endmodule

// File: tb/tb_axon_delay_line.sv
// Bench for axon_delay_line: directed table, corner sequences and random traffic against a release-time model.
// The model tracks absolute release edge numbers per channel in queues, independent of any wrapping counter.
module tb_axon_delay_line;
    import axon_pkg::*;

    localparam int N_CH  = 4;
    localparam int DEPTH = 8;
    localparam int CW    = CH_IDX_W;
    localparam int NTBL  = 19;

    typedef struct {
        logic [N_CH-1:0]    spk;
        logic               we;
        logic [CW-1:0]      ch;
        logic [DELAY_W-1:0] dly;
        logic [N_CH-1:0]    exp_out;
        logic               exp_ack;
        logic               exp_err;
    } vec_t;

    logic               clock = 1'b0;
    logic               reset;
    logic [N_CH-1:0]    spike_in;
    logic [N_CH-1:0]    spike_out;
    logic               cfg_we;
    logic [CW-1:0]      cfg_ch;
    logic [DELAY_W-1:0] cfg_delay;
    logic               cfg_ack;
    logic               cfg_err;
    logic [N_CH-1:0]    busy;
    logic [N_CH-1:0]    overflow;
    logic               ovf_clr;

    always #5 clock = ~clock;

    axon_delay_line #(.N_CH(N_CH), .DEPTH(DEPTH), .DEFAULT_DELAY(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .spike_in  (spike_in),
        .spike_out (spike_out),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_delay (cfg_delay),
        .cfg_ack   (cfg_ack),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int edge_no = 0;

    int              rel_q   [N_CH][$];
    int              m_delay [N_CH];
    logic [N_CH-1:0] m_out, m_busy, m_ovf;
    logic            m_ack, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
        end
    endtask

    task automatic set_idle();
        spike_in  = '0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_delay = '0;
        ovf_clr   = 1'b0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            rel_q[c].delete();
            m_delay[c] = 1;
        end
        m_out   = '0;
        m_busy  = '0;
        m_ovf   = '0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        edge_no = 0;
    endtask

    // Apply the currently driven inputs for one edge, advance the model and compare every output.
    task automatic step();
        logic [N_CH-1:0]    s, was_busy, set;
        logic               we, clr;
        logic [CW-1:0]      ch;
        logic [DELAY_W-1:0] dly;
        int                 eff;
        s = spike_in; we = cfg_we; ch = cfg_ch; dly = cfg_delay; clr = ovf_clr;
        @(posedge clock);
        edge_no++;
        for (int c = 0; c < N_CH; c++) begin
            was_busy[c] = rel_q[c].size() > 0;
            m_out[c]    = 1'b0;
            set[c]      = 1'b0;
            if (rel_q[c].size() > 0 && rel_q[c][0] == edge_no) begin
                void'(rel_q[c].pop_front());
                m_out[c] = 1'b1;
            end
            eff = (m_delay[c] == 0) ? 1 : m_delay[c];
            if (s[c]) begin
                if (rel_q[c].size() < DEPTH) rel_q[c].push_back(edge_no + eff);
                else                         set[c] = 1'b1;
            end
            m_busy[c] = rel_q[c].size() > 0;
        end
        m_ovf = set | (clr ? '0 : m_ovf);
        m_ack = 1'b0;
        m_err = 1'b0;
        if (we) begin
            m_err = 1'b1;
            if (int'(ch) < N_CH) begin
                if (!was_busy[ch] && !s[ch]) begin
                    m_ack = 1'b1;
                    m_err = 1'b0;
                    m_delay[ch] = int'(dly);
                end
            end
        end
        #1;
        check("spike_out", 32'(spike_out), 32'(m_out));
        check("busy",      32'(busy),      32'(m_busy));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("cfg_ack",   32'(cfg_ack),   32'(m_ack));
        check("cfg_err",   32'(cfg_err),   32'(m_err));
    endtask

    vec_t tbl [NTBL];

    initial begin
        int e0, p, s1, s2;

        for (int i = 0; i < NTBL; i++) tbl[i] = '{default: '0};
        // Row i is applied at edge i+1; expectations are the outputs right after that edge.
        tbl[4].spk     = 4'b0001;
        tbl[5].exp_out = 4'b0001;
        tbl[6].we = 1'b1;  tbl[6].ch = 3'd2;  tbl[6].dly = 6'd10; tbl[6].exp_ack = 1'b1;
        tbl[7].we = 1'b1;  tbl[7].ch = 3'd5;  tbl[7].dly = 6'd3;  tbl[7].exp_err = 1'b1;
        tbl[8].spk     = 4'b0100;
        tbl[9].we = 1'b1;  tbl[9].ch = 3'd2;  tbl[9].dly = 6'd4;  tbl[9].exp_err = 1'b1;
        tbl[10].spk = 4'b1000; tbl[10].we = 1'b1; tbl[10].ch = 3'd3; tbl[10].exp_err = 1'b1;
        tbl[11].we = 1'b1; tbl[11].ch = 3'd3; tbl[11].exp_out = 4'b1000; tbl[11].exp_err = 1'b1;
        tbl[12].we = 1'b1; tbl[12].ch = 3'd3; tbl[12].exp_ack = 1'b1;
        tbl[13].spk     = 4'b1000;
        tbl[14].exp_out = 4'b1000;
        tbl[18].exp_out = 4'b0100;

        reset = 1'b1;
        set_idle();
        repeat (3) @(posedge clock);
        #1;
        check("rst_spike_out", 32'(spike_out), 32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_overflow",  32'(overflow),  32'h0);
        check("rst_cfg_ack",   32'(cfg_ack),   32'h0);
        check("rst_cfg_err",   32'(cfg_err),   32'h0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < NTBL; i++) begin
            spike_in  = tbl[i].spk;
            cfg_we    = tbl[i].we;
            cfg_ch    = tbl[i].ch;
            cfg_delay = tbl[i].dly;
            ovf_clr   = 1'b0;
            step();
            check($sformatf("tbl%0d_out", i), 32'(spike_out), 32'(tbl[i].exp_out));
            check($sformatf("tbl%0d_ack", i), 32'(cfg_ack),   32'(tbl[i].exp_ack));
            check($sformatf("tbl%0d_err", i), 32'(cfg_err),   32'(tbl[i].exp_err));
        end

        // Channel 2 at delay 10: spikes at +1, +2, +6 release at +11, +12, +16.
        e0 = edge_no;
        for (int k = 1; k <= 17; k++) begin
            set_idle();
            spike_in[2] = (k == 1 || k == 2 || k == 6);
            step();
            check("ch2_pulse", 32'(spike_out[2]), 32'(k == 11 || k == 12 || k == 16));
            if (k >= 15) check("ch2_busy", 32'(busy[2]), 32'(k == 15));
        end

        // Channel 1 at delay 20: fill, overflow, clear, then push into a full FIFO while it pops.
        set_idle();
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_delay = 6'd20;
        step();
        check("ch1_cfg_ack", 32'(cfg_ack), 32'h1);
        p = edge_no + 1;
        for (int k = 0; k < 10; k++) begin
            set_idle();
            spike_in[1] = 1'b1;
            ovf_clr     = (k == 9);
            step();
            if (k >= 7) check("ch1_ovf_fill", 32'(overflow[1]), 32'(k >= 8));
        end
        set_idle();
        ovf_clr = 1'b1;
        step();
        check("ch1_ovf_clr", 32'(overflow[1]), 32'h0);
        set_idle();
        while (edge_no < p + 19) step();
        for (int k = 0; k < 2; k++) begin
            set_idle();
            spike_in[1] = 1'b1;
            step();
            check("ch1_full_pop", 32'(spike_out[1]), 32'h1);
            check("ch1_full_ovf", 32'(overflow[1]),  32'h0);
        end
        set_idle();
        while (edge_no < p + 41) begin
            step();
            if (edge_no >= p + 40) check("ch1_refill_pulse", 32'(spike_out[1]), 32'h1);
        end

        // Channel 0 at delay 63 with spikes at now=60 and now=62, straddling the counter wrap.
        set_idle();
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_delay = 6'd63;
        step();
        check("ch0_cfg_ack", 32'(cfg_ack), 32'h1);
        set_idle();
        while (edge_no % 64 != 60) step();
        s1 = edge_no + 1;
        spike_in[0] = 1'b1;
        step();
        set_idle();
        step();
        s2 = edge_no + 1;
        spike_in[0] = 1'b1;
        step();
        set_idle();
        while (edge_no < s2 + 63) begin
            step();
            if (edge_no == s1 + 63 || edge_no == s2 + 63)
                check("ch0_wrap_pulse", 32'(spike_out[0]), 32'h1);
        end

        // Reset with spikes in flight on every channel.
        spike_in = 4'b1111;
        step();
        spike_in = 4'b0111;
        step();
        set_idle();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy",      32'(busy),      32'h0);
        check("midrst_spike_out", 32'(spike_out), 32'h0);
        check("midrst_overflow",  32'(overflow),  32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 70; k++) step();

        // Random traffic with alternating light and heavy spike density.
        for (int i = 0; i < 1600; i++) begin
            if ((i / 200) % 2 == 0) spike_in = N_CH'($urandom) & N_CH'($urandom);
            else                    spike_in = N_CH'($urandom) | N_CH'($urandom);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_ch    = CW'($urandom_range(0, 7));
            cfg_delay = ($urandom_range(0, 3) == 0) ? DELAY_W'($urandom) : DELAY_W'($urandom_range(0, 12));
            ovf_clr   = ($urandom_range(0, 15) == 0);
            step();
        end
        set_idle();
        for (int k = 0; k < 70; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
